id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register with built-in load-use hazard detection. Captures the decoded
//  control words (EX/MEM/WB), register operands, immediate and register addresses
//  from decode each cycle and presents them to EX. Inserts a bubble on load-use hazard or
//  branch/jump flush, and drives stall_o back to the PC and IF/ID register.
// PARAMETERS
//  DATA_W   32  width of register operands and immediate
//  REG_AW   5   register-file address width
//  CNT_W    16  width of statistics counters (used only with ID_EX_STATS_EN)
// PORTS
//  clk_i         in   1       clock, all state on rising edge
//  rst_n_i       in   1       asynchronous active-low reset
//  ex_ctrl_i     in   5       {ALUop[2:0], ALUsrc, RegDst} from control
//  mem_ctrl_i    in   2       {MEM_cs, MEM_we}
//  wb_ctrl_i     in   2       {WB_mux, Reg_we}
//  rs_data_i     in   DATA_W  register-file read port A
//  rt_data_i     in   DATA_W  register-file read port B
//  imm_i         in   DATA_W  sign-extended immediate
//  rs_addr_i     in   REG_AW  instruction rs field
//  rt_addr_i     in   REG_AW  instruction rt field
//  rd_addr_i     in   REG_AW  instruction rd field
//  rt_used_i     in   1       decode: instruction reads rt as a source (R-type, SW, BEQ)
//  flush_i       in   1       branch taken / jump: discard the instruction in ID
//  hold_i        in   1       global freeze (memory busy): keep all state
//  ex_ctrl_o .. rd_addr_o  out  same widths as inputs, registered copies
//  valid_o       out  1       EX stage holds a real instruction
//  stall_o       out  1       combinational: hold PC and IF/ID this cycle
// BEHAVIOUR
//  - Reset (async, rst_n_i=0): every registered output 0, valid_o=0; counters 0.
//  - Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
//  - ex_is_load = valid_o & mem_ctrl_o==2'b10 & wb_ctrl_o[0].
//  - hazard = ex_is_load & rt_addr_o!=0 &
//      (rt_addr_o==rs_addr_i | (rt_used_i & rt_addr_o==rt_addr_i)).
//  - stall_o = hazard & ~flush_i & ~hold_i (pure combinational, no register).
//  - Per-edge priority: hold_i > flush_i > hazard > load.
//    hold_i : all registers keep value (including valid_o); stall_o=0 (freeze is global).
//    flush_i: bubble -> ex/mem/wb ctrl = 0, valid_o=0; data/addr fields don't-care (zeroed).
//    hazard : bubble as above; the ID instruction is retained upstream via stall_o and
//             re-presented next cycle, where hazard is now clear (one bubble per load-use).
//    else   : capture all inputs, valid_o=1.
//  - Control bits are captured as-is; undriven bits in fields unused by an
//    instruction pass through unchanged; downstream must gate on Reg_we / MEM_cs.
//  - Reset asserted mid-operation clears state immediately; first edge after release
//    behaves as normal load (no bubble owed).
//  - Register $0 never causes a hazard.
// CONFIGURATION
//  - Macro ID_EX_STATS_EN: when defined, adds outputs bubble_cnt_o / flush_cnt_o
//    (CNT_W each), incremented on every hazard bubble / flush edge not under hold_i,
//    saturating at all-ones, cleared by reset. When undefined, ports and logic absent.
// STRUCTURE
//  - Shared header PipelineDefs.v: `define widths of EX/MEM/WB ctrl words, field bit
//    positions (MEM_cs, MEM_we, Reg_we, WB_mux), and `BUBBLE_EX/MEM/WB zero constants.
//  - Sub-module id_ex_hazard_unit: combinational hazard/stall_o detector (ports: EX-stage
//    rt/ctrl/valid, ID rs/rt/rt_used, flush, hold -> hazard, stall).
//  - Top: hazard unit instance + one always block for the pipeline register (+ counters).
// TESTING
//  1. Reset: rst_n_i=0 with random inputs -> all outputs 0, valid_o=0, stall_o=0.
//  2. ADD r3,r1,r2 (ex=5'b010_0_1, wb=2'b11) then edge -> outputs equal inputs, valid_o=1.
//  3. LW r5 then ADD r6,r5,r2 (rs=5) -> stall_o=1 one cycle, one bubble (ctrl=0, valid 0),
//     ADD in EX on following edge; repeat with rt=5, rt_used_i=0 -> no stall.
//  4. LW r0 followed by user of r0 -> stall_o=0, no bubble.
//  5. flush_i=1 concurrent with hazard -> stall_o=0, bubble inserted, flush_cnt_o +1.
//  6. hold_i=1 for 3 cycles mid-stream -> outputs frozen, stall_o=0; reset pulse during
//     hold -> outputs clear asynchronously before next edge.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Control-word layout, bubble constants and action encoding shared by the ID/EX stage.
package id_ex_stage_pkg;

  localparam int EX_CTRL_W  = 5;
  localparam int MEM_CTRL_W = 2;
  localparam int WB_CTRL_W  = 2;

  localparam int MEM_CS_BIT = 1;
  localparam int MEM_WE_BIT = 0;
  localparam int WB_MUX_BIT = 1;
  localparam int REG_WE_BIT = 0;

  localparam logic [EX_CTRL_W-1:0]  BUBBLE_EX  = '0;
  localparam logic [MEM_CTRL_W-1:0] BUBBLE_MEM = '0;
  localparam logic [WB_CTRL_W-1:0]  BUBBLE_WB  = '0;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_HOLD   = 2'd3
  } id_ex_action_e;

  // A load reads memory (cs=1, we=0) and writes the register file.
  function automatic logic is_load(input logic [MEM_CTRL_W-1:0] mem, input logic reg_we);
    return mem[MEM_CS_BIT] & ~mem[MEM_WE_BIT] & reg_we;
  endfunction

endpackage

// File: rtl/id_ex_hazard_unit.sv
// Combinational load-use detector: compares the load in EX against the sources in ID.
module id_ex_hazard_unit
  import id_ex_stage_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic                  i_ex_valid,
  input  logic [MEM_CTRL_W-1:0] i_ex_mem_ctrl,
  input  logic                  i_ex_reg_we,
  input  logic [REG_AW-1:0]     i_ex_rt_addr,
  input  logic [REG_AW-1:0]     i_id_rs_addr,
  input  logic [REG_AW-1:0]     i_id_rt_addr,
  input  logic                  i_id_rt_used,
  input  logic                  i_flush,
  input  logic                  i_hold,
  output logic                  o_hazard,
  output logic                  o_stall
);

  logic w_ex_is_load;
  logic w_src_match;

  assign w_ex_is_load = i_ex_valid & is_load(i_ex_mem_ctrl, i_ex_reg_we);
  assign w_src_match  = (i_ex_rt_addr == i_id_rs_addr) |
                        (i_id_rt_used & (i_ex_rt_addr == i_id_rt_addr));

  // $0 is hard-wired, so a load into it can never be a real dependency.
  assign o_hazard = w_ex_is_load & (i_ex_rt_addr != '0) & w_src_match;
  assign o_stall  = o_hazard & ~i_flush & ~i_hold;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush/hold handling.
// Optional ID_EX_STATS_EN macro adds saturating bubble/flush counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
`ifdef ID_EX_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [EX_CTRL_W-1:0]  ex_ctrl_i,
  input  logic [MEM_CTRL_W-1:0] mem_ctrl_i,
  input  logic [WB_CTRL_W-1:0]  wb_ctrl_i,
  input  logic [DATA_W-1:0]     rs_data_i,
  input  logic [DATA_W-1:0]     rt_data_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic [REG_AW-1:0]     rs_addr_i,
  input  logic [REG_AW-1:0]     rt_addr_i,
  input  logic [REG_AW-1:0]     rd_addr_i,
  input  logic                  rt_used_i,
  input  logic                  flush_i,
  input  logic                  hold_i,
  output logic [EX_CTRL_W-1:0]  ex_ctrl_o,
  output logic [MEM_CTRL_W-1:0] mem_ctrl_o,
  output logic [WB_CTRL_W-1:0]  wb_ctrl_o,
  output logic [DATA_W-1:0]     rs_data_o,
  output logic [DATA_W-1:0]     rt_data_o,
  output logic [DATA_W-1:0]     imm_o,
  output logic [REG_AW-1:0]     rs_addr_o,
  output logic [REG_AW-1:0]     rt_addr_o,
  output logic [REG_AW-1:0]     rd_addr_o,
  output logic                  valid_o,
  output logic                  stall_o
`ifdef ID_EX_STATS_EN
  , output logic [CNT_W-1:0]    bubble_cnt_o
  , output logic [CNT_W-1:0]    flush_cnt_o
`endif
);

  logic [EX_CTRL_W-1:0]  r_ex_ctrl;
  logic [MEM_CTRL_W-1:0] r_mem_ctrl;
  logic [WB_CTRL_W-1:0]  r_wb_ctrl;
  logic [DATA_W-1:0]     r_rs_data;
  logic [DATA_W-1:0]     r_rt_data;
  logic [DATA_W-1:0]     r_imm;
  logic [REG_AW-1:0]     r_rs_addr;
  logic [REG_AW-1:0]     r_rt_addr;
  logic [REG_AW-1:0]     r_rd_addr;
  logic                  r_valid;

  logic                  w_hazard;
  logic                  w_stall;
  id_ex_action_e         w_action;

  id_ex_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .i_ex_valid    (r_valid),
    .i_ex_mem_ctrl (r_mem_ctrl),
    .i_ex_reg_we   (r_wb_ctrl[REG_WE_BIT]),
    .i_ex_rt_addr  (r_rt_addr),
    .i_id_rs_addr  (rs_addr_i),
    .i_id_rt_addr  (rt_addr_i),
    .i_id_rt_used  (rt_used_i),
    .i_flush       (flush_i),
    .i_hold        (hold_i),
    .o_hazard      (w_hazard),
    .o_stall       (w_stall)
  );

  always_comb begin
    w_action = ACT_LOAD;
    if (hold_i)        w_action = ACT_HOLD;
    else if (flush_i)  w_action = ACT_FLUSH;
    else if (w_hazard) w_action = ACT_BUBBLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ex_ctrl  <= BUBBLE_EX;
      r_mem_ctrl <= BUBBLE_MEM;
      r_wb_ctrl  <= BUBBLE_WB;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_rs_addr  <= '0;
      r_rt_addr  <= '0;
      r_rd_addr  <= '0;
      r_valid    <= 1'b0;
    end else begin
      case (w_action)
        ACT_HOLD: ;
        ACT_FLUSH, ACT_BUBBLE: begin
          r_ex_ctrl  <= BUBBLE_EX;
          r_mem_ctrl <= BUBBLE_MEM;
          r_wb_ctrl  <= BUBBLE_WB;
          r_rs_data  <= '0;
          r_rt_data  <= '0;
          r_imm      <= '0;
          r_rs_addr  <= '0;
          r_rt_addr  <= '0;
          r_rd_addr  <= '0;
          r_valid    <= 1'b0;
        end
        default: begin
          r_ex_ctrl  <= ex_ctrl_i;
          r_mem_ctrl <= mem_ctrl_i;
          r_wb_ctrl  <= wb_ctrl_i;
          r_rs_data  <= rs_data_i;
          r_rt_data  <= rt_data_i;
          r_imm      <= imm_i;
          r_rs_addr  <= rs_addr_i;
          r_rt_addr  <= rt_addr_i;
          r_rd_addr  <= rd_addr_i;
          r_valid    <= 1'b1;
        end
      endcase
    end
  end

`ifdef ID_EX_STATS_EN
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_action == ACT_BUBBLE && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 1'b1;
      if (w_action == ACT_FLUSH && r_flush_cnt != '1)   r_flush_cnt  <= r_flush_cnt + 1'b1;
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
  assign flush_cnt_o  = r_flush_cnt;
`endif

  assign ex_ctrl_o  = r_ex_ctrl;
  assign mem_ctrl_o = r_mem_ctrl;
  assign wb_ctrl_o  = r_wb_ctrl;
  assign rs_data_o  = r_rs_data;
  assign rt_data_o  = r_rt_data;
  assign imm_o      = r_imm;
  assign rs_addr_o  = r_rs_addr;
  assign rt_addr_o  = r_rt_addr;
  assign rd_addr_o  = r_rd_addr;
  assign valid_o    = r_valid;
  assign stall_o    = w_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: expected EX contents queued per edge.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [4:0]  ex_ctrl_i;
  logic [1:0]  mem_ctrl_i, wb_ctrl_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
  logic        rt_used_i, flush_i, hold_i;
  logic [4:0]  ex_ctrl_o;
  logic [1:0]  mem_ctrl_o, wb_ctrl_o;
  logic [31:0] rs_data_o, rt_data_o, imm_o;
  logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
  logic        valid_o, stall_o;
`ifdef ID_EX_STATS_EN
  logic [15:0] bubble_cnt_o, flush_cnt_o;
  int          m_bub, m_fl;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  ex;
    logic [1:0]  mem;
    logic [1:0]  wb;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        valid;
  } st_t;

  st_t m;
  st_t sb[$];

  always #5 clk_i = ~clk_i;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .ex_ctrl_i(ex_ctrl_i), .mem_ctrl_i(mem_ctrl_i), .wb_ctrl_i(wb_ctrl_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .rt_used_i(rt_used_i), .flush_i(flush_i), .hold_i(hold_i),
    .ex_ctrl_o(ex_ctrl_o), .mem_ctrl_o(mem_ctrl_o), .wb_ctrl_o(wb_ctrl_o),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
    .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
    .valid_o(valid_o), .stall_o(stall_o)
`ifdef ID_EX_STATS_EN
    , .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input st_t e);
    chk({tag, ".ex"},    32'(ex_ctrl_o),  32'(e.ex));
    chk({tag, ".mem"},   32'(mem_ctrl_o), 32'(e.mem));
    chk({tag, ".wb"},    32'(wb_ctrl_o),  32'(e.wb));
    chk({tag, ".rsd"},   rs_data_o,       e.rs_d);
    chk({tag, ".rtd"},   rt_data_o,       e.rt_d);
    chk({tag, ".imm"},   imm_o,           e.imm);
    chk({tag, ".rs"},    32'(rs_addr_o),  32'(e.rs));
    chk({tag, ".rt"},    32'(rt_addr_o),  32'(e.rt));
    chk({tag, ".rd"},    32'(rd_addr_o),  32'(e.rd));
    chk({tag, ".valid"}, 32'(valid_o),    32'(e.valid));
  endtask

  // One decode cycle: drive ID, check stall_o, queue the expected EX contents, clock, compare.
  task automatic step(input string tag, input logic [4:0] ex, input logic [1:0] mem,
                      input logic [1:0] wb, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic used, input logic flush,
                      input logic hold, input logic exp_stall);
    st_t nx;
    logic hz;
    ex_ctrl_i = ex; mem_ctrl_i = mem; wb_ctrl_i = wb;
    rs_addr_i = rs; rt_addr_i = rt; rd_addr_i = rd;
    rt_used_i = used; flush_i = flush; hold_i = hold;
    rs_data_i = $urandom; rt_data_i = $urandom; imm_i = $urandom;
    #1;
    hz = m.valid && m.mem == 2'b10 && m.wb[0] && m.rt != 5'd0 &&
         (m.rt == rs || (used && m.rt == rt));
    chk({tag, ".stall"}, 32'(stall_o), 32'(exp_stall));
    chk({tag, ".stall_model"}, 32'(stall_o), 32'(hz & ~flush & ~hold));
    if (hold)            nx = m;
    else if (flush | hz) nx = '0;
    else nx = '{ex: ex, mem: mem, wb: wb, rs_d: rs_data_i, rt_d: rt_data_i, imm: imm_i,
                rs: rs, rt: rt, rd: rd, valid: 1'b1};
`ifdef ID_EX_STATS_EN
    if (!hold && flush) m_fl++;
    else if (!hold && hz) m_bub++;
`endif
    sb.push_back(nx);
    @(posedge clk_i);
    #1;
    m = sb.pop_front();
    chk_outputs(tag, m);
`ifdef ID_EX_STATS_EN
    chk({tag, ".bubcnt"}, 32'(bubble_cnt_o), 32'(m_bub));
    chk({tag, ".flcnt"},  32'(flush_cnt_o),  32'(m_fl));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m = '0;
`ifdef ID_EX_STATS_EN
    m_bub = 0; m_fl = 0;
`endif
    rst_n_i = 1'b0;
    ex_ctrl_i = 5'($urandom); mem_ctrl_i = 2'b10; wb_ctrl_i = 2'b11;
    rs_data_i = $urandom; rt_data_i = $urandom; imm_i = $urandom;
    rs_addr_i = 5'd7; rt_addr_i = 5'd7; rd_addr_i = 5'($urandom);
    rt_used_i = 1'b1; flush_i = 1'b0; hold_i = 1'b0;
    #3;
    chk_outputs("reset_pre", '0);
    chk("reset_pre.stall", 32'(stall_o), 32'd0);
    #9;
    chk_outputs("reset_post_edge", '0);
    chk("reset_post_edge.stall", 32'(stall_o), 32'd0);
    rst_n_i = 1'b1;

    // ADD r3,r1,r2
    step("add",      5'b01001, 2'b00, 2'b11, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    // LW r5 then ADD r6,r5,r2: one bubble then ADD re-presented
    step("lw5a",     5'b00010, 2'b10, 2'b11, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("use_rs5",  5'b01001, 2'b00, 2'b11, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    step("rep_rs5",  5'b01001, 2'b00, 2'b11, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    // rt match but rt not a source: no stall
    step("lw5b",     5'b00010, 2'b10, 2'b11, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rt5_nouse",5'b00010, 2'b00, 2'b11, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // rt match with rt used (SW-style): stall
    step("lw5c",     5'b00010, 2'b10, 2'b11, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("sw_rt5",   5'b00010, 2'b11, 2'b00, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("rep_sw",   5'b00010, 2'b11, 2'b00, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    // LW r0 then user of r0: never a hazard
    step("lw0",      5'b00010, 2'b10, 2'b11, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("use_r0",   5'b01001, 2'b00, 2'b11, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    // flush concurrent with hazard: no stall, bubble
    step("lw5d",     5'b00010, 2'b10, 2'b11, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("flush_hz", 5'b01001, 2'b00, 2'b11, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    step("after_fl", 5'b01001, 2'b00, 2'b11, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    // hold for three cycles with a pending hazard: frozen, no stall
    step("lw5e",     5'b00010, 2'b10, 2'b11, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("hold",   5'b01001, 2'b00, 2'b11, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    // asynchronous reset pulse while held
    rst_n_i = 1'b0;
    #1;
    m = '0;
`ifdef ID_EX_STATS_EN
    m_bub = 0; m_fl = 0;
`endif
    chk_outputs("async_rst", '0);
    chk("async_rst.stall", 32'(stall_o), 32'd0);
    #1;
    rst_n_i = 1'b1;
    step("post_rst", 5'b01001, 2'b00, 2'b11, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    // load after a hold-free restart still produces exactly one bubble
    step("lw7",      5'b00010, 2'b10, 2'b11, 5'd2, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("use_rt7",  5'b01001, 2'b00, 2'b11, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    step("rep_rt7",  5'b01001, 2'b00, 2'b11, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
